// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
// The optional round-robin build is selected with MEM_ARBITER_RR_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  localparam int STARVE_MAX_DEFAULT = 4;
  // Wide enough for the full 1..15 starvation range.
  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between the fetch and data requesters.
// MEM_ARBITER_RR_EN selects round-robin; otherwise d wins unless fetch is starved.
module arb_pick
  import mem_arb_pkg::*;
`ifndef MEM_ARBITER_RR_EN
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
)
`endif
(
  input  logic                    i_req,
  input  logic                    d_req,
`ifdef MEM_ARBITER_RR_EN
  input  req_id_t                 last_gnt,
`else
  input  logic [STARVE_CNT_W-1:0] starve_cnt,
`endif
  output logic                    win_valid,
  output req_id_t                 win_id
);

`ifndef MEM_ARBITER_RR_EN
  localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);
`endif

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    win_valid = i_req | d_req;
    win_id    = REQ_D;
    if (i_req && !d_req) begin
      win_id = REQ_I;
    end else if (i_req && d_req) begin
`ifdef MEM_ARBITER_RR_EN
      win_id = (last_gnt == REQ_D) ? REQ_I : REQ_D;
`else
      if (starve_cnt == STARVE_LIM) win_id = REQ_I;
`endif
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between fetch (i) and data (d) requesters,
// one transaction at a time. MEM_ARBITER_RR_EN swaps fixed priority for round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic              win_valid;
  req_id_t           win_id;
  logic              done_i, done_d;

`ifdef MEM_ARBITER_RR_EN
  req_id_t last_q;

  arb_pick u_pick (
    .i_req     (i_req),
    .d_req     (d_req),
    .last_gnt  (last_q),
    .win_valid (win_valid),
    .win_id    (win_id)
  );
`else
  localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);
  localparam logic [STARVE_CNT_W-1:0] CNT_ONE    = STARVE_CNT_W'(1);

  logic [STARVE_CNT_W-1:0] starve_q;

  arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .starve_cnt (starve_q),
    .win_valid  (win_valid),
    .win_id     (win_id)
  );
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Grants are gated by reset so nothing is offered while the block is held in reset.
  always_comb begin
    state_d = state_q;
    i_gnt   = 1'b0;
    d_gnt   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_valid && reset) begin
          if (win_id == REQ_I) begin
            i_gnt   = 1'b1;
            state_d = BUSY_I;
          end else begin
            d_gnt   = 1'b1;
            state_d = BUSY_D;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory side is driven purely from the latched request, so stalls hold it stable.
  assign mem_en    = (state_q != IDLE);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // NOTE: only control and datapath registers are reset; there is no memory array here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (i_gnt) begin
      addr_q  <= i_addr;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (d_gnt) begin
      addr_q  <= d_addr;
      we_q    <= d_we;
      wdata_q <= d_wdata;
    end
  end

  assign done_i = (state_q == BUSY_I) && mem_ready;
  assign done_d = (state_q == BUSY_D) && mem_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      i_rvalid <= done_i;
      d_rvalid <= done_d;
      if (done_i)          i_rdata <= mem_rdata;
      // Store completions leave the load data register untouched.
      if (done_d && !we_q) d_rdata <= mem_rdata;
    end
  end

`ifdef MEM_ARBITER_RR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     last_q <= REQ_D;
    else if (i_gnt) last_q <= REQ_I;
    else if (d_gnt) last_q <= REQ_D;
  end
`else
  // Counts data grants that bypassed a waiting fetch; any idle gap without a fetch forgives them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
    end else if (i_gnt) begin
      starve_q <= '0;
    end else if (d_gnt && i_req) begin
      if (starve_q != STARVE_LIM) starve_q <= starve_q + CNT_ONE;
    end else if ((state_q == IDLE) && !i_req) begin
      starve_q <= '0;
    end
  end
`endif

endmodule
